muldiv_ctrl: RTL



---
 rtl/muldiv_ctrl_pkg.sv | 14 +
 rtl/muldiv_step.sv | 18 +
 rtl/muldiv_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: op and state encodings shared by the sequencer and the ID-stage decoder
package muldiv_ctrl_pkg;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on the double-width accumulator
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opd_i,
   input  logic               div_i,
   output logic [2*WIDTH-1:0] acc_o
);
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   assign sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, acc_i[0] ? opd_i : {WIDTH{1'b0}}};
   assign rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
   assign diff   = {1'b0, rem_sh} - {2'b00, opd_i};
   assign acc_o  = div_i ? {diff[WIDTH+1] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc_i[WIDTH-2:0], ~diff[WIDTH+1]}
                         : {sum, acc_i[WIDTH-1:1]};
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that stalls the pipeline and delivers HI/LO
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] DIVZ_Q = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d, rneg_q, rneg_d;
   logic               sgn_op, div_op, a_neg, b_neg, divz;
   logic [WIDTH-1:0]   abs_a, abs_b, quo, rem, hi_fix, lo_fix;
   assign sgn_op = (op_q == OP_MULT) | (op_q == OP_DIV);
   assign div_op = (op_q == OP_DIV) | (op_q == OP_DIVU);
   assign a_neg  = sgn_op & a_q[WIDTH-1];
   assign b_neg  = sgn_op & b_q[WIDTH-1];
   assign abs_a  = a_neg ? -a_q : a_q;
   assign abs_b  = b_neg ? -b_q : b_q;
   assign divz   = b_q == '0;
   assign prod   = neg_q ? -acc_q : acc_q;
   assign quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   assign hi_fix = !div_op ? prod[2*WIDTH-1:WIDTH] : divz ? a_q : rem;
   assign lo_fix = !div_op ? prod[WIDTH-1:0] : divz ? DIVZ_Q : quo;
   assign busy   = (state_q == S_PREP) | (state_q == S_RUN) | (state_q == S_FIX);
   assign stall  = busy | (start & (state_q == S_IDLE));
   assign done   = state_q == S_DONE;
   assign hi     = hi_q;
   assign lo     = lo_q;
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc_i (acc_q),
      .opd_i (opd_q),
      .div_i (div_op),
      .acc_o (step_acc)
   );
   // state and datapath registers; reset clears the committed result too
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         opd_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         opd_q   <= opd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
   // next state: latch on start, prepare magnitudes, iterate, sign-fix and commit; flush aborts
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      opd_d   = opd_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: if (start && !flush) begin
            state_d = S_PREP;
            op_d    = op;
            a_d     = a;
            b_d     = b;
         end
         S_PREP: begin
            state_d = flush ? S_IDLE : S_RUN;
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            opd_d   = abs_b;
            cnt_d   = CW'(WIDTH - 1);
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
         end
         S_RUN: begin
            state_d = flush ? S_IDLE : (cnt_q == '0) ? S_FIX : S_RUN;
            acc_d   = step_acc;
            cnt_d   = cnt_q - 1'b1;
         end
         S_FIX: begin
            state_d = flush ? S_IDLE : S_DONE;
            hi_d    = flush ? hi_q : hi_fix;
            lo_d    = flush ? lo_q : lo_fix;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule
